decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width of out_pc/out_imm/in_pc; legal values 32 or 64.
REQ-002 Parameter SKID, 1, 1 = two-entry skid buffer; 0 = single output register, in_ready combinationally tied to out_ready || !out_valid.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous kill of all buffered entries.
REQ-006 in_valid  input  1; in_ready  output  1; in_instr  input  32; in_pc  input  XLEN: fetch-side handshake and payload.
REQ-007 out_valid  output  1; out_ready  input  1: execute-side handshake.
REQ-008 out_pc  output  XLEN; out_rd, out_rs1, out_rs2  output  5 each: pass-through PC and register indices.
REQ-009 out_imm  output  XLEN  sign-extended immediate.
REQ-010 out_alucontrol  output  4; out_result_src  output  2 (0 ALU, 1 load data, 2 PC+4); out_alu_src_imm  output  1.
REQ-011 out_reg_write, out_mem_write, out_branch, out_jump, out_illegal  output  1 each.

Function
REQ-012 Transfer on a port SHALL occur only in a cycle where valid && ready are both high.
REQ-013 Latency SHALL be exactly one cycle: an instruction accepted at edge N appears on out_* after edge N when the buffer was empty.
REQ-014 Decoded opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI; any other opcode SHALL set out_illegal=1.
REQ-015 R/I ALU alucontrol by funct3: 000 add 0 / sub 1, 100 xor 4, 110 or 3, 111 and 2, 001 sll 5, 101 srl 6 / sra 7, 010 slt 9, 011 sltu 8.
REQ-016 Sub (1) SHALL be selected only for R-type with instr[30]=1; ADDI SHALL always give 0.
REQ-017 SLLI with funct7!=0, SRLI/SRAI with funct7 not in {0x00,0x20}, R-type with other funct7 SHALL be illegal.
REQ-018 Branch alucontrol by funct3: 000 0, 001 1, 100 2, 101 3, 110 4, 111 5; funct3 010/011 SHALL be illegal.
REQ-019 Load/store/JALR SHALL use alucontrol 0 with out_alu_src_imm=1; LUI SHALL use alucontrol 0 with rs1 forced to 0.
REQ-020 Immediates SHALL be I/S/B/U/J formats per RV32I, sign-extended from instr[31] to XLEN.
REQ-021 out_reg_write SHALL be 1 for R, I-ALU, load, JAL, JALR, LUI with rd!=0, else 0; out_mem_write only for store.
REQ-022 Illegal entries SHALL force out_reg_write=0, out_mem_write=0, out_branch=0, out_jump=0, all other fields unchanged.
REQ-023 SKID=1: in_ready SHALL be registered, low only when the skid entry is occupied; entries SHALL leave in acceptance order.
REQ-024 Simultaneous accept and output transfer with one entry held SHALL keep occupancy at one without a bubble.
REQ-025 flush SHALL empty both entries at the next edge, overriding a same-cycle acceptance; in_ready SHALL be 1 the following cycle.
REQ-026 out_* payload SHALL hold stable while out_valid && !out_ready.

Reset
REQ-027 On rst_n low: out_valid=0, skid empty, in_ready=1 once rst_n is high, all payload outputs 0.
REQ-028 Reset mid-transfer SHALL discard all entries; no instruction held at assertion SHALL appear after release.

Structure
REQ-029 Opcode constants, ALUCTL_* codes, RESULT_* codes and decoded-control struct SHALL live in shared package riscv_pkg.
REQ-030 Combinational decode SHALL be sub-module decode_comb; decode_stage SHALL own the handshake and buffering only.

Verification
REQ-031 0x002081B3 (add x3,x1,x2) -> next cycle rd=3, rs1=1, rs2=2, alucontrol=0, reg_write=1, illegal=0.
REQ-032 0x402081B3 -> alucontrol=1; 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, alucontrol=0, alu_src_imm=1.
REQ-033 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC, branch=1, alucontrol=0, reg_write=0.
REQ-034 0x00000000 -> illegal=1, reg_write=0, mem_write=0.
REQ-035 out_ready=0 for 3 cycles while two instructions offered -> both accepted, in_ready=0 after second, order preserved on release.
REQ-036 flush with both entries full -> out_valid=0 and in_ready=1 next cycle; rst_n pulse mid-stream -> no stale output.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU and result-select codes, decoded control bundle.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALUCTL_ADD  = 4'd0;
   localparam logic [3:0] ALUCTL_SUB  = 4'd1;
   localparam logic [3:0] ALUCTL_AND  = 4'd2;
   localparam logic [3:0] ALUCTL_OR   = 4'd3;
   localparam logic [3:0] ALUCTL_XOR  = 4'd4;
   localparam logic [3:0] ALUCTL_SLL  = 4'd5;
   localparam logic [3:0] ALUCTL_SRL  = 4'd6;
   localparam logic [3:0] ALUCTL_SRA  = 4'd7;
   localparam logic [3:0] ALUCTL_SLTU = 4'd8;
   localparam logic [3:0] ALUCTL_SLT  = 4'd9;

   localparam logic [1:0] RESULT_ALU = 2'd0;
   localparam logic [1:0] RESULT_MEM = 2'd1;
   localparam logic [1:0] RESULT_PC4 = 2'd2;

   typedef struct packed {
      logic [3:0] alucontrol;
      logic [1:0] result_src;
      logic       alu_src_imm;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       illegal;
   } ctrl_t;

   // alt selects sub/sra; callers decide when instr[30] is allowed to mean that
   function automatic logic [3:0] alu_by_funct3(input logic [2:0] funct3, input logic alt);
      logic [3:0] code;
      case (funct3)
         3'b000:  code = alt ? ALUCTL_SUB : ALUCTL_ADD;
         3'b001:  code = ALUCTL_SLL;
         3'b010:  code = ALUCTL_SLT;
         3'b011:  code = ALUCTL_SLTU;
         3'b100:  code = ALUCTL_XOR;
         3'b101:  code = alt ? ALUCTL_SRA : ALUCTL_SRL;
         3'b110:  code = ALUCTL_OR;
         default: code = ALUCTL_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction decoder: register indices, immediate and control bundle.
module decode_comb
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output ctrl_t           ctrl
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm32;
   logic        bad;
   ctrl_t       c;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign rd     = instr[11:7];
   assign rs2    = instr[24:20];
   assign imm    = XLEN'($signed(imm32));

   always_comb begin
      c     = '0;
      imm32 = '0;
      bad   = 1'b0;
      rs1   = instr[19:15];
      case (opcode)
         OP_R: begin
            c.reg_write  = 1'b1;
            c.alucontrol = alu_by_funct3(funct3, instr[30]);
            if (funct3 == 3'b000 || funct3 == 3'b101) begin
               bad = (funct7 != 7'h00) && (funct7 != 7'h20);
            end else begin
               bad = (funct7 != 7'h00);
            end
         end
         OP_IALU: begin
            c.reg_write   = 1'b1;
            c.alu_src_imm = 1'b1;
            imm32         = {{20{instr[31]}}, instr[31:20]};
            // Only shifts carry a funct7; ADDI never becomes sub
            c.alucontrol  = alu_by_funct3(funct3, (funct3 == 3'b101) && instr[30]);
            if (funct3 == 3'b001) begin
               bad = (funct7 != 7'h00);
            end else if (funct3 == 3'b101) begin
               bad = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
         end
         OP_LOAD: begin
            c.reg_write   = 1'b1;
            c.alu_src_imm = 1'b1;
            c.result_src  = RESULT_MEM;
            imm32         = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            c.mem_write   = 1'b1;
            c.alu_src_imm = 1'b1;
            imm32         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            c.branch = 1'b1;
            imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            case (funct3)
               3'b000:  c.alucontrol = 4'd0;
               3'b001:  c.alucontrol = 4'd1;
               3'b100:  c.alucontrol = 4'd2;
               3'b101:  c.alucontrol = 4'd3;
               3'b110:  c.alucontrol = 4'd4;
               3'b111:  c.alucontrol = 4'd5;
               default: bad = 1'b1;
            endcase
         end
         OP_JAL: begin
            c.reg_write  = 1'b1;
            c.jump       = 1'b1;
            c.result_src = RESULT_PC4;
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_JALR: begin
            c.reg_write   = 1'b1;
            c.jump        = 1'b1;
            c.alu_src_imm = 1'b1;
            c.result_src  = RESULT_PC4;
            imm32         = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LUI: begin
            c.reg_write   = 1'b1;
            c.alu_src_imm = 1'b1;
            rs1           = 5'd0;
            imm32         = {instr[31:12], 12'h000};
         end
         default: bad = 1'b1;
      endcase
      c.illegal   = bad;
      c.reg_write = c.reg_write && (rd != 5'd0) && !bad;
      c.mem_write = c.mem_write && !bad;
      c.branch    = c.branch && !bad;
      c.jump      = c.jump && !bad;
      ctrl        = c;
   end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: valid/ready handshake around decode_comb with an optional two-entry skid.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SKID = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [3:0]      out_alucontrol,
   output logic [1:0]      out_result_src,
   output logic            out_alu_src_imm,
   output logic            out_reg_write,
   output logic            out_mem_write,
   output logic            out_branch,
   output logic            out_jump,
   output logic            out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      ctrl_t           ctrl;
   } entry_t;

   entry_t          in_entry, head_q, head_d, skid_q, skid_d;
   logic            head_valid_q, head_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
   logic            in_fire;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rd, dec_rs1, dec_rs2;
   ctrl_t           dec_ctrl;

   decode_comb #(.XLEN(XLEN)) u_decode (
      .instr (in_instr),
      .imm   (dec_imm),
      .rd    (dec_rd),
      .rs1   (dec_rs1),
      .rs2   (dec_rs2),
      .ctrl  (dec_ctrl)
   );

   always_comb begin
      in_entry      = '0;
      in_entry.pc   = in_pc;
      in_entry.imm  = dec_imm;
      in_entry.rd   = dec_rd;
      in_entry.rs1  = dec_rs1;
      in_entry.rs2  = dec_rs2;
      in_entry.ctrl = dec_ctrl;
   end

   assign in_ready = (SKID != 0) ? in_ready_q : (out_ready || !head_valid_q);
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      head_d       = head_q;
      head_valid_d = head_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!head_valid_q || out_ready) begin
         // Head is free this cycle: older skid entry goes first to keep order
         if (skid_valid_q) begin
            head_d       = skid_q;
            head_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            head_valid_d = in_fire;
            if (in_fire) head_d = in_entry;
         end
      end else if (in_fire && (SKID != 0)) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q       <= '0;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

   assign out_valid       = head_valid_q;
   assign out_pc          = head_q.pc;
   assign out_imm         = head_q.imm;
   assign out_rd          = head_q.rd;
   assign out_rs1         = head_q.rs1;
   assign out_rs2         = head_q.rs2;
   assign out_alucontrol  = head_q.ctrl.alucontrol;
   assign out_result_src  = head_q.ctrl.result_src;
   assign out_alu_src_imm = head_q.ctrl.alu_src_imm;
   assign out_reg_write   = head_q.ctrl.reg_write;
   assign out_mem_write   = head_q.ctrl.mem_write;
   assign out_branch      = head_q.ctrl.branch;
   assign out_jump        = head_q.ctrl.jump;
   assign out_illegal     = head_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, stall/skid, flush and reset cases.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [3:0]  alu;
      logic [1:0]  rsrc;
      logic        asi, rw, mw, br, jp, ill;
   } exp_t;

   localparam int NV = 16;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [3:0]  out_alucontrol;
   logic [1:0]  out_result_src;
   logic        out_alu_src_imm, out_reg_write, out_mem_write, out_branch, out_jump, out_illegal;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [31:0] vi[NV];
   exp_t ve[NV];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .SKID(1)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .in_pc           (in_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_rd          (out_rd),
      .out_rs1         (out_rs1),
      .out_rs2         (out_rs2),
      .out_imm         (out_imm),
      .out_alucontrol  (out_alucontrol),
      .out_result_src  (out_result_src),
      .out_alu_src_imm (out_alu_src_imm),
      .out_reg_write   (out_reg_write),
      .out_mem_write   (out_mem_write),
      .out_branch      (out_branch),
      .out_jump        (out_jump),
      .out_illegal     (out_illegal)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // flags = {alu_src_imm, reg_write, mem_write, branch, jump, illegal}
   function automatic exp_t ev(input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [3:0] alu,
                               input logic [1:0] rsrc, input logic [5:0] flags);
      exp_t e;
      e = '{pc: 32'h0, imm: imm, rd: rd, rs1: rs1, rs2: rs2, alu: alu, rsrc: rsrc,
            asi: flags[5], rw: flags[4], mw: flags[3], br: flags[2], jp: flags[1], ill: flags[0]};
      return e;
   endfunction

   // Monitor: every output transfer must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t act;
      if (rst_n && out_valid && out_ready) begin
         act = {out_pc, out_imm, out_rd, out_rs1, out_rs2, out_alucontrol, out_result_src,
                out_alu_src_imm, out_reg_write, out_mem_write, out_branch, out_jump, out_illegal};
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got pc %h instr output with empty scoreboard", out_pc);
         end else begin
            chk("out_payload", 128'(act), 128'(sb.pop_front()));
         end
      end
   end

   task automatic send(input logic [31:0] ins, input exp_t e, output int waits);
      logic acc;
      acc      = 1'b0;
      waits    = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = e.pc;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            sb.push_back(e);
         end else begin
            waits++;
            @(posedge clk);
            #1;
         end
      end
      chk("in_accept", 128'(acc), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
      #1;
      chk(name, 128'(sb.size()), 128'(0));
   endtask

   initial begin
      int   w;
      int   total;
      exp_t e;
      vi[0]  = 32'h002081B3; ve[0]  = ev(32'h0,        3,  1,  2,  0, 0, 6'b010000);
      vi[1]  = 32'h402081B3; ve[1]  = ev(32'h0,        3,  1,  2,  1, 0, 6'b010000);
      vi[2]  = 32'hFFF00093; ve[2]  = ev(32'hFFFFFFFF, 1,  0,  31, 0, 0, 6'b110000);
      vi[3]  = 32'hFE208EE3; ve[3]  = ev(32'hFFFFFFFC, 29, 1,  2,  0, 0, 6'b000100);
      vi[4]  = 32'h00000000; ve[4]  = ev(32'h0,        0,  0,  0,  0, 0, 6'b000001);
      vi[5]  = 32'h123452B7; ve[5]  = ev(32'h12345000, 5,  0,  3,  0, 0, 6'b110000);
      vi[6]  = 32'h00812303; ve[6]  = ev(32'h8,        6,  2,  8,  0, 1, 6'b110000);
      vi[7]  = 32'hFE712E23; ve[7]  = ev(32'hFFFFFFFC, 28, 2,  7,  0, 0, 6'b101000);
      vi[8]  = 32'h010000EF; ve[8]  = ev(32'h10,       1,  0,  16, 0, 2, 6'b010010);
      vi[9]  = 32'h00008067; ve[9]  = ev(32'h0,        0,  1,  0,  0, 2, 6'b100010);
      vi[10] = 32'h40335293; ve[10] = ev(32'h403,      5,  6,  3,  7, 0, 6'b110000);
      vi[11] = 32'h02331293; ve[11] = ev(32'h23,       5,  6,  3,  5, 0, 6'b100001);
      vi[12] = 32'hFE20CEE3; ve[12] = ev(32'hFFFFFFFC, 29, 1,  2,  2, 0, 6'b000100);
      vi[13] = 32'hFE20AEE3; ve[13] = ev(32'hFFFFFFFC, 29, 1,  2,  0, 0, 6'b000001);
      vi[14] = 32'h0020B1B3; ve[14] = ev(32'h0,        3,  1,  2,  8, 0, 6'b010000);
      vi[15] = 32'h022081B3; ve[15] = ev(32'h0,        3,  1,  2,  0, 0, 6'b000001);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_payload", {out_pc, out_imm, out_rd, out_rs1, out_rs2, out_alucontrol},
          128'(0));
      chk("rst_ctrl", {out_result_src, out_alu_src_imm, out_reg_write, out_mem_write,
                       out_branch, out_jump, out_illegal}, 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;

      // Isolated vectors: one-cycle latency from an empty buffer
      for (int i = 0; i < NV; i++) begin
         e = ve[i];
         e.pc = 32'h1000 + 32'(i * 4);
         send(vi[i], e, w);
         @(negedge clk);
         chk("latency_valid", 128'(out_valid), 128'(1));
         @(posedge clk); #1;
      end
      drain("drain_isolated");

      // Back-to-back stream: no bubbles with the consumer always ready
      total = 0;
      for (int i = 0; i < NV; i++) begin
         e = ve[NV - 1 - i];
         e.pc = 32'h2000 + 32'(i * 4);
         send(vi[NV - 1 - i], e, w);
         total += w;
      end
      chk("stream_waits", 128'(total), 128'(0));
      drain("drain_stream");

      // Stall: two accepted into head and skid, order kept on release
      out_ready = 1'b0;
      e = ve[0]; e.pc = 32'h3000; send(vi[0], e, w);
      e = ve[7]; e.pc = 32'h3004; send(vi[7], e, w);
      @(negedge clk);
      chk("skid_in_ready", 128'(in_ready), 128'(0));
      chk("skid_out_valid", 128'(out_valid), 128'(1));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stall_hold_pc", 128'(out_pc), 128'(32'h3000));
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain("drain_skid");

      // Flush with both entries held
      out_ready = 1'b0;
      e = ve[2]; e.pc = 32'h4000; send(vi[2], e, w);
      e = ve[5]; e.pc = 32'h4004; send(vi[5], e, w);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("flush_out_valid", 128'(out_valid), 128'(0));
      chk("flush_in_ready", 128'(in_ready), 128'(1));
      // Flush overrides an acceptance in the same cycle
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = vi[6]; in_pc = 32'h4008; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_override", 128'(out_valid), 128'(0));
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-stream discards held entries
      out_ready = 1'b0;
      e = ve[8]; e.pc = 32'h5000; send(vi[8], e, w);
      e = ve[9]; e.pc = 32'h5004; send(vi[9], e, w);
      rst_n = 1'b0;
      sb.delete();
      #2;
      chk("rstmid_out_valid", 128'(out_valid), 128'(0));
      chk("rstmid_payload", {out_pc, out_imm, out_reg_write, out_jump}, 128'(0));
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_in_ready", 128'(in_ready), 128'(1));
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstmid_no_stale", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
      e = ve[12]; e.pc = 32'h6000; send(vi[12], e, w);
      drain("drain_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
